// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and types for the matrix RAM row loader
package matrix_pkg;
  localparam int ELEM_W    = 16;
  localparam int ROW_ELEMS = 16;
  localparam int ROW_W     = ELEM_W * ROW_ELEMS;
  localparam int ADDR_W    = 5;
  localparam int DEPTH     = 16;
  localparam int CNT_W     = $clog2(ROW_ELEMS);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;
endpackage

// File: rtl/matrix_row_loader_row_packer.sv
// rtl/matrix_row_loader_row_packer.sv - packs ROW_ELEMS elements into one row, element 0 at the LSBs
// row_data includes the element accepted this cycle, so row_valid can be registered straight into the RAM port.
module row_packer
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              elem_valid,
  input  logic [ELEM_W-1:0] elem_data,
  output logic              row_valid,
  output logic [ROW_W-1:0]  row_data
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  row_t             pack_q, pack_d;

  always_comb begin
    cnt_d     = cnt_q;
    pack_d    = pack_q;
    row_valid = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (elem_valid) begin
      for (int k = 0; k < ROW_ELEMS; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          pack_d[k*ELEM_W +: ELEM_W] = elem_data;
        end
      end
      if (cnt_q == CNT_W'(ROW_ELEMS - 1)) begin
        row_valid = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign row_data = pack_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pack_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/matrix_row_loader.sv
// rtl/matrix_row_loader.sv - streams 16-bit elements into 256-bit rows written to the matrix RAM
// Optional abort input/aborted output enabled by defining ROW_LOADER_ABORT_EN.
module matrix_row_loader
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        num_rows,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ROW_W-1:0]  ram_d,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic              busy,
  output logic              done
`ifdef ROW_LOADER_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        rows_q, rows_d;
  logic [4:0]        row_cnt_q, row_cnt_d;
  row_t              ram_d_q, ram_d_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wen_q, ram_wen_d;
  logic              done_q, done_d;
  logic              pack_clr;
  logic              row_valid;
  row_t              row_data;
  logic              abort_hit;

`ifdef ROW_LOADER_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_hit = abort && (state_q == LOAD);

  always_comb begin
    aborted_d = abort_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= aborted_d;
  end

  assign aborted = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);

  row_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pack_clr),
    .elem_valid (in_valid && in_ready),
    .elem_data  (in_data),
    .row_valid  (row_valid),
    .row_data   (row_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rows_d     = rows_q;
    row_cnt_d  = row_cnt_q;
    ram_d_d    = ram_d_q;
    ram_addr_d = ram_addr_q;
    ram_wen_d  = 1'b0;
    done_d     = 1'b0;
    pack_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d    = num_rows;
          addr_d    = base_addr & ADDR_MASK;
          row_cnt_d = '0;
          if (num_rows == 5'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // Abort wins over a row completing in the same cycle: that write is dropped.
        if (abort_hit) begin
          pack_clr = 1'b1;
          state_d  = IDLE;
        end else if (row_valid) begin
          ram_wen_d  = 1'b1;
          ram_d_d    = row_data;
          ram_addr_d = addr_q;
          addr_d     = (addr_q + 1'b1) & ADDR_MASK;
          row_cnt_d  = row_cnt_q + 5'd1;
          if (row_cnt_q + 5'd1 == rows_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rows_q     <= '0;
      row_cnt_q  <= '0;
      ram_d_q    <= '0;
      ram_addr_q <= '0;
      ram_wen_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rows_q     <= rows_d;
      row_cnt_q  <= row_cnt_d;
      ram_d_q    <= ram_d_d;
      ram_addr_q <= ram_addr_d;
      ram_wen_q  <= ram_wen_d;
      done_q     <= done_d;
    end
  end

  assign ram_d    = ram_d_q;
  assign ram_addr = ram_addr_q;
  assign ram_wen  = ram_wen_q;
  assign done     = done_q;

endmodule

// File: tb/tb_matrix_row_loader.sv
// tb/tb_matrix_row_loader.sv - directed self-checking bench for matrix_row_loader
module tb_matrix_row_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [4:0]   base_addr;
  logic [4:0]   num_rows;
  logic [15:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] ram_d;
  logic [4:0]   ram_addr;
  logic         ram_wen;
  logic         busy;
  logic         done;
`ifdef ROW_LOADER_ABORT_EN
  logic         abort;
  logic         aborted;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [4:0]   wr_addr[$];
  logic [255:0] wr_data[$];
  int           wr_cyc[$];
  int           done_cyc;
  int           done_cnt;
  bit           ready_seen;
  int           c0;

  always #5 clk = ~clk;

  matrix_row_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ram_d     (ram_d),
    .ram_addr  (ram_addr),
    .ram_wen   (ram_wen),
    .busy      (busy),
    .done      (done)
`ifdef ROW_LOADER_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ram_wen === 1'b1) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_d);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (in_ready === 1'b1) ready_seen = 1'b1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc   = -1;
    done_cnt   = 0;
    ready_seen = 1'b0;
  endtask

  function automatic logic [255:0] exp_row(input logic [15:0] seed, input int r);
    logic [255:0] v;
    for (int k = 0; k < 16; k++) v[16*k +: 16] = seed + 16'(16*r + k);
    return v;
  endfunction

  // Streams elements seed, seed+1, ... ; stop_after>0 leaves the load early after that many handshakes.
  task automatic run_load(input logic [4:0] base, input logic [4:0] nrows, input bit rnd,
                          input logic [15:0] seed, input bit hold_start, input int stop_after);
    int idx;
    int budget;
    bit hs;
    clear_log();
    idx       = 0;
    budget    = 64 * int'(nrows) + 50;
    start     = 1'b1;
    base_addr = base;
    num_rows  = nrows;
    in_data   = seed;
    in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    c0        = cyc;
    while (done_cnt == 0 && budget > 0) begin
      hs = in_valid && in_ready;
      tick();
      budget--;
      if (hold_start) begin
        start     = (done_cnt == 0);
        base_addr = 5'd8;
        num_rows  = 5'd5;
      end else begin
        start = 1'b0;
      end
      if (hs) idx++;
      if (stop_after > 0 && idx == stop_after) return;
      in_data  = seed + 16'(idx);
      in_valid = (idx < 16 * int'(nrows)) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    chk("done_within_budget", done_cnt != 0, 1'b1);
    chk("in_ready_low_at_done", in_ready, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("busy_low_after_done", busy, 1'b0);
    chk("done_single_pulse", done_cnt, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    in_data   = '0;
    in_valid  = 1'b0;
`ifdef ROW_LOADER_ABORT_EN
    abort     = 1'b0;
`endif
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_ram_wen", ram_wen, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ram_d", ram_d, 256'd0);
    chk("rst_ram_addr", ram_addr, 5'd0);
    rst_n = 1'b1;
    tick();

    // single row, back-to-back stream
    run_load(5'd3, 5'd1, 1'b0, 16'h0001, 1'b0, 0);
    chk("r1_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("r1_wen_cycle", wr_cyc[0] - c0, 17);
      chk("r1_addr", wr_addr[0], 5'd3);
      chk("r1_d_lsb", wr_data[0][15:0], 16'h0001);
      chk("r1_d_msb", wr_data[0][255:240], 16'h0010);
      chk("r1_d_full", wr_data[0], exp_row(16'h0001, 0));
    end
    chk("r1_done_cycle", done_cyc - c0, 17);

    // wrap 15 -> 0, start held high with junk config while busy
    run_load(5'd15, 5'd2, 1'b0, 16'h0100, 1'b1, 0);
    chk("r2_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("r2_addr0", wr_addr[0], 5'd15);
      chk("r2_addr1", wr_addr[1], 5'd0);
      chk("r2_spacing", wr_cyc[1] - wr_cyc[0], 16);
      chk("r2_d0", wr_data[0], exp_row(16'h0100, 0));
      chk("r2_d1", wr_data[1], exp_row(16'h0100, 1));
    end
    chk("r2_done_cycle", done_cyc - c0, 33);

    // zero rows
    run_load(5'd6, 5'd0, 1'b0, 16'h0000, 1'b0, 0);
    chk("r0_done_cycle", done_cyc - c0, 1);
    chk("r0_nwr", wr_addr.size(), 0);
    chk("r0_ready_never", ready_seen, 1'b0);

    // full 16 rows with random valid gaps
    run_load(5'd5, 5'd16, 1'b1, 16'h1000, 1'b0, 0);
    chk("r16_nwr", wr_addr.size(), 16);
    if (wr_addr.size() == 16) begin
      for (int r = 0; r < 16; r++) begin
        chk($sformatf("r16_addr%0d", r), wr_addr[r], 5'((5 + r) % 16));
        chk($sformatf("r16_data%0d", r), wr_data[r], exp_row(16'h1000, r));
      end
    end

    // reset mid-row, then a clean load from a new base
    run_load(5'd7, 5'd2, 1'b0, 16'h3000, 1'b0, 8);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk("mr_in_ready", in_ready, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_ram_wen", ram_wen, 1'b0);
    chk("mr_done", done, 1'b0);
    chk("mr_ram_d", ram_d, 256'd0);
    chk("mr_ram_addr", ram_addr, 5'd0);
    chk("mr_no_write", wr_addr.size(), 0);
    rst_n = 1'b1;
    tick();
    run_load(5'd9, 5'd1, 1'b0, 16'h2000, 1'b0, 0);
    chk("mr2_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("mr2_addr", wr_addr[0], 5'd9);
      chk("mr2_data", wr_data[0], exp_row(16'h2000, 0));
    end

`ifdef ROW_LOADER_ABORT_EN
    chk("ab_idle_aborted", aborted, 1'b0);
    run_load(5'd2, 5'd3, 1'b0, 16'h4000, 1'b0, 21);
    in_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_aborted_pulse", aborted, 1'b1);
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    tick();
    chk("ab_aborted_clear", aborted, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("ab_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("ab_addr", wr_addr[0], 5'd2);
      chk("ab_data", wr_data[0], exp_row(16'h4000, 0));
    end
    chk("ab_done_never", done_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_row_loader.md
Name: matrix_row_loader

Overview:
Upstream load stage for the 16-entry x 256-bit dual-port matrix RAM. Accepts a narrow valid/ready stream of 16-bit matrix elements and packs 16 elements into one 256-bit row. Writes each completed row through one RAM port (d/addr/wen) at consecutive addresses starting at a programmable base. Signals completion after a programmed number of rows.

Parameters:
ELEM_W, 16, element width in bits
ROW_ELEMS, 16, elements per RAM row (ELEM_W*ROW_ELEMS = 256)
ADDR_W, 5, RAM address width
DEPTH, 16, number of RAM rows; row address wraps modulo DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle load request, sampled only in IDLE
base_addr  in  5  first RAM row written, latched on start
num_rows  in  5  rows to load, 0..16, latched on start
in_data  in  16  element stream data
in_valid  in  1  element stream valid
in_ready  out  1  element stream ready
ram_d  out  256  row data to RAM port
ram_addr  out  5  row address to RAM port
ram_wen  out  1  RAM write enable, one-cycle pulse per row
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; in_ready, ram_wen, done, busy = 0; ram_d = 0; ram_addr = 0; element and row counters = 0; partial row discarded, no RAM write.
- FSM states: IDLE, LOAD, DONE.
- IDLE: start=1 latches base_addr and num_rows. If num_rows=0 -> DONE with no write. Otherwise -> LOAD.
- LOAD: in_ready = 1 (combinational from state). Each handshake (in_valid & in_ready) stores in_data at bits [16k+15:16k], k = element count 0..15; element 0 is at the LSBs.
- 16th handshake of a row: the next cycle drives ram_wen=1, ram_d=packed row, ram_addr=current row address. The packing counter clears in the same cycle, so one element/cycle sustained throughput with no bubble.
- Row address increments modulo DEPTH after each write; bit 4 of ram_addr is always 0 (15 -> 0 wrap).
- 16th handshake of the final row: LOAD -> DONE and in_ready deasserts the next cycle.
- DONE: lasts one cycle with done=1; the final row's ram_wen=1 is asserted in this same cycle (or done alone if num_rows=0). Then -> IDLE.
- Latency: start at cycle 0 with in_valid held high -> first ram_wen at cycle 17; N rows -> done at cycle 16N+1.
- start while busy: ignored, with no effect on the latched config.
- in_valid=0 stalls packing; no timeout.
- ram_wen, ram_d, ram_addr, done are registered outputs. ram_d holds its last value when ram_wen=0.

Optional Feature:
Macro ROW_LOADER_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit, reset 0).
- abort=1 in LOAD discards the partial row and suppresses any pending ram_wen not yet issued. The FSM returns to IDLE next cycle with aborted=1 for one cycle and done stays 0.
- abort in IDLE/DONE is ignored.
- Undefined: ports absent; LOAD exits only via row completion or reset.

Decomposition:
- Package matrix_pkg: ELEM_W, ROW_ELEMS, ROW_W=256, ADDR_W, DEPTH constants; typedef logic [255:0] row_t; typedef enum {IDLE, LOAD, DONE} loader_state_t.
- One natural sub-module, row_packer: element counter plus 256-bit pack register; emits row_t with a row_valid pulse on the 16th element; clearable.
- FSM, address counter and row counter stay in matrix_row_loader.

Test Plan:
- base_addr=3, num_rows=1, elements 0x0001..0x0010 streamed back-to-back -> single ram_wen at cycle 17, ram_addr=3, ram_d[15:0]=0x0001, ram_d[255:240]=0x0010, done=1 same cycle, busy=0 next cycle.
- base_addr=15, num_rows=2 -> writes at addr 15 then addr 0, exactly 2 ram_wen pulses 16 cycles apart.
- num_rows=0 -> done one cycle after start, no ram_wen, in_ready never asserted.
- num_rows=16, in_valid toggled randomly -> 16 writes at addrs base..base+15 mod 16, data matches the input order, in_ready=0 after the final handshake.
- rst_n=0 after the 8th element of row 0 -> all outputs 0 next cycle, no ram_wen; a new start then loads cleanly from the latched new base.
- ROW_LOADER_ABORT_EN defined, abort after the 5th element of row 1 of 3 -> row 0 written, aborted=1 one cycle, no further ram_wen, done never asserted.
